// File: rtl/memory_arbiter.sv
// memory_arbiter: single-port RAM arbiter for instruction fetch and data access.
// Ports:
//   CLK, RST               clock, synchronous active-high reset
//   iREN, iaddr            fetch request and address
//   ihit, imemload         fetch-complete pulse and last fetched word
//   dREN, dWEN, daddr,     data read/write request, address and store data
//   dstore
//   dhit, dmemload         data-complete pulse and last loaded word
//   halt                   blocks new fetch grants
//   ramREN, ramWEN,        RAM strobes, address and write data
//   ramaddr, ramstore
//   ramload, ram_ready     RAM read data and completion
//   timeout_err            sticky flag: RAM failed to complete within TIMEOUT cycles
module memory_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    input  logic        halt,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic [7:0] LIMIT = 8'(TIMEOUT);
    state_t state, next;
    logic src_d, wr;
    logic [31:0] addr_q, store_q;
    logic [7:0] cnt;
    logic grant_d, grant_i, expired, discard;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        grant_d = dWEN || dREN;
        grant_i = iREN && !halt;
        expired = cnt == LIMIT;
        // a fetch whose request vanished or moved (branch/jump flush) is stale
        discard = !src_d && (!iREN || iaddr != addr_q);
        next    = state;
        case (state)
            IDLE:    next = (grant_d || grant_i) ? ACCESS : IDLE;
            ACCESS:  next = ram_ready ? (discard ? IDLE : RESP) : (expired ? IDLE : ACCESS);
            default: next = IDLE;
        endcase
        ramREN   = state == ACCESS && !wr;
        ramWEN   = state == ACCESS && wr;
        ramaddr  = addr_q;
        ramstore = store_q;
        ihit     = state == RESP && !src_d;
        dhit     = state == RESP && src_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            src_d       <= 1'b0;
            wr          <= 1'b0;
            addr_q      <= '0;
            store_q     <= '0;
            cnt         <= '0;
            imemload    <= '0;
            dmemload    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == IDLE && (grant_d || grant_i)) begin
                src_d   <= grant_d;
                wr      <= dWEN;
                addr_q  <= grant_d ? daddr : iaddr;
                store_q <= dstore;
                cnt     <= 8'd1;
            end
            if (state == ACCESS) begin
                cnt <= cnt + 8'd1;
                if (ram_ready) begin
                    if (src_d && !wr) dmemload <= ramload;
                    if (!src_d && !discard) imemload <= ramload;
                end else if (expired) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scoreboard bench for memory_arbiter (TIMEOUT=4).
module tb_memory_arbiter;
    logic        CLK = 1'b0;
    logic        RST, iREN, dREN, dWEN, halt, ram_ready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        ihit, dhit, ramREN, ramWEN, timeout_err;
    logic [31:0] imemload, dmemload, ramaddr, ramstore;

    typedef struct packed {
        logic        d;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];
    exp_t e_mon;
    int checks = 0;
    int fails = 0;

    memory_arbiter #(.TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .imemload(imemload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dhit(dhit), .dmemload(dmemload),
        .halt(halt), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ready(ram_ready), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    // scoreboard monitor: every hit pops one expected response
    always @(negedge CLK) begin
        if (!RST && (ihit || dhit)) begin
            if (ihit && dhit) chk("hit_onehot", 32'({ihit, dhit}), 32'd1);
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_hit: got ihit=%b dhit=%b expected no hit", ihit, dhit);
            end else begin
                e_mon = q.pop_front();
                chk("hit_src", 32'(dhit), 32'(e_mon.d));
                chk("hit_data", dhit ? dmemload : imemload, e_mon.data);
            end
        end
    end

    initial begin
        RST = 1; iREN = 0; dREN = 0; dWEN = 0; halt = 0; ram_ready = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
        step(); step();
        RST = 0;
        chk("rst_hits", 32'({ihit, dhit}), 32'd0);
        chk("rst_strobes", 32'({ramREN, ramWEN}), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_ramstore", ramstore, 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        chk("rst_dmemload", dmemload, 32'd0);

        // fetch, ram_ready in third ACCESS cycle
        iREN = 1; iaddr = 32'h100;
        q.push_back('{1'b0, 32'h8C220004});
        for (int c = 1; c <= 3; c++) begin
            step();
            chk("fetch_ren", 32'(ramREN), 32'd1);
            chk("fetch_addr", ramaddr, 32'h100);
        end
        ram_ready = 1; ramload = 32'h8C220004;
        step();
        ram_ready = 0; iREN = 0;
        chk("fetch_ihit", 32'(ihit), 32'd1);
        chk("fetch_strobe_resp", 32'(ramREN), 32'd0);
        step();
        chk("fetch_idle_hit", 32'(ihit), 32'd0);
        chk("fetch_hold", imemload, 32'h8C220004);

        // priority: data read wins over simultaneous fetch
        iREN = 1; iaddr = 32'h100; dREN = 1; daddr = 32'h200;
        q.push_back('{1'b1, 32'h11112222});
        q.push_back('{1'b0, 32'h33334444});
        step();
        chk("prio_addr_d", ramaddr, 32'h200);
        ram_ready = 1; ramload = 32'h11112222;
        step();
        ram_ready = 0; dREN = 0;
        chk("prio_dhit", 32'(dhit), 32'd1);
        step();
        chk("prio_idle", 32'(ramREN), 32'd0);
        step();
        chk("prio_addr_i", ramaddr, 32'h100);
        ram_ready = 1; ramload = 32'h33334444;
        step();
        ram_ready = 0; iREN = 0;
        chk("prio_ihit", 32'(ihit), 32'd1);
        step();

        // write wins over read; dmemload untouched
        dWEN = 1; dREN = 1; daddr = 32'h300; dstore = 32'hDEADBEEF;
        q.push_back('{1'b1, 32'h11112222});
        step();
        chk("wr_wen", 32'(ramWEN), 32'd1);
        chk("wr_ren", 32'(ramREN), 32'd0);
        chk("wr_addr", ramaddr, 32'h300);
        chk("wr_store", ramstore, 32'hDEADBEEF);
        ram_ready = 1; ramload = 32'hFFFF0000;
        step();
        ram_ready = 0; dWEN = 0; dREN = 0;
        chk("wr_dhit", 32'(dhit), 32'd1);
        step();

        // flush discard: fetch address moves mid-access
        iREN = 1; iaddr = 32'h100;
        q.push_back('{1'b0, 32'h55556666});
        step();
        chk("flush_addr0", ramaddr, 32'h100);
        iaddr = 32'h240;
        step();
        ram_ready = 1; ramload = 32'hAAAAAAAA;
        step();
        ram_ready = 0;
        chk("flush_no_ihit", 32'(ihit), 32'd0);
        chk("flush_keep", imemload, 32'h33334444);
        chk("flush_idle", 32'(ramREN), 32'd0);
        step();
        chk("flush_addr1", ramaddr, 32'h240);
        chk("flush_ren1", 32'(ramREN), 32'd1);
        ram_ready = 1; ramload = 32'h55556666;
        step();
        ram_ready = 0; iREN = 0;
        chk("flush_ihit", 32'(ihit), 32'd1);
        step();

        // timeout after 4 ACCESS cycles, then re-grant
        dREN = 1; daddr = 32'h400;
        for (int c = 1; c <= 4; c++) begin
            step();
            chk("to_ren", 32'(ramREN), 32'd1);
            chk("to_err_low", 32'(timeout_err), 32'd0);
        end
        step();
        chk("to_drop", 32'(ramREN), 32'd0);
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_no_dhit", 32'(dhit), 32'd0);
        step();
        chk("to_regrant", 32'(ramREN), 32'd1);
        q.push_back('{1'b1, 32'h77778888});
        ram_ready = 1; ramload = 32'h77778888;
        step();
        ram_ready = 0; dREN = 0;
        chk("to_dhit", 32'(dhit), 32'd1);
        step();
        chk("to_sticky", 32'(timeout_err), 32'd1);

        // halt blocks fetch grants
        halt = 1; iREN = 1; iaddr = 32'h500;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("halt_strobes", 32'({ramREN, ramWEN}), 32'd0);
        end
        halt = 0; iREN = 0;
        step();

        // reset in ACCESS with ram_ready at the same edge
        dREN = 1; daddr = 32'h600;
        step();
        chk("rst_acc_ren", 32'(ramREN), 32'd1);
        RST = 1; ram_ready = 1; ramload = 32'h99999999;
        step();
        chk("rst2_hits", 32'({ihit, dhit}), 32'd0);
        chk("rst2_strobes", 32'({ramREN, ramWEN}), 32'd0);
        chk("rst2_err", 32'(timeout_err), 32'd0);
        chk("rst2_ramaddr", ramaddr, 32'd0);
        chk("rst2_ramstore", ramstore, 32'd0);
        chk("rst2_imemload", imemload, 32'd0);
        chk("rst2_dmemload", dmemload, 32'd0);
        RST = 0; dREN = 0; ram_ready = 0;
        step();
        chk("rst2_after_hits", 32'({ihit, dhit}), 32'd0);
        step();
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Single-port memory arbiter that answers the datapath's instruction-fetch and data-access requests with one-cycle `ihit`/`dhit` pulses and returned load data. These are the hit signals the pipeline stall and flush logic consumes. It sits between the pipelined datapath and the single-port RAM. Data requests take priority over fetches. It drops a fetch whose address changed mid-access because of a branch or jump flush, and flags a sticky error if the RAM never completes an access.

## Interface
- `TIMEOUT`, default 255: maximum number of ACCESS cycles before the arbiter abandons the access. Legal range is 1..255, held in an 8-bit counter.
- `CLK`  in  1  — the block's one clock; everything is registered on its rising edge.
- `RST`  in  1  — synchronous, active-high reset.
- `iREN`  in  1  — instruction fetch request.
- `iaddr`  in  32  — fetch address (PC).
- `ihit`  out  1  — one-cycle pulse: fetch completed.
- `imemload`  out  32  — last fetched word; holds until the next completed fetch.
- `dREN` / `dWEN`  in  1 / 1  — data read / data write request.
- `daddr`, `dstore`  in  32 / 32  — data address and write data.
- `dhit`  out  1  — one-cycle pulse: data access completed.
- `dmemload`  out  32  — last loaded word; holds until the next completed read.
- `halt`  in  1  — while high, no new fetch is granted. Data requests are still served.
- `ramREN`, `ramWEN`  out  1 / 1  — RAM read / write strobes.
- `ramaddr`, `ramstore`  out  32 / 32  — RAM address and write data.
- `ramload`  in  32  — RAM read data; valid in the cycle `ram_ready` is high.
- `ram_ready`  in  1  — RAM access complete. Sampled only in ACCESS.
- `timeout_err`  out  1  — sticky error flag; cleared only by reset.

## Operation
- States: IDLE, ACCESS, RESP.
- **IDLE** arbitration:
  - `dWEN` → grant a D write. This takes priority over `dREN` if both are high.
  - else `dREN` → grant a D read.
  - else `iREN && !halt` → grant an I read.
  - else stay in IDLE.
- On a grant, the arbiter latches the source (I/D), the address, the store data and the direction, then moves to ACCESS.
- **ACCESS**:
  - `ramREN`/`ramWEN`/`ramaddr`/`ramstore` come from registers and are stable for the whole state.
  - The cycle counter starts at 1 and increments each ACCESS cycle.
- **ram_ready in ACCESS**, resolved in this order:
  - I read, and (`!iREN` or `iaddr` differs from the latched address): discard. `imemload` is not updated, no `ihit`, go to IDLE. The next IDLE refetches.
  - I read otherwise: `imemload <= ramload`, go to RESP.
  - D read: `dmemload <= ramload`, go to RESP. A D read is never discarded.
  - D write: go to RESP. `dmemload` is unchanged.
- **Timeout**: if the counter equals `TIMEOUT` and `ram_ready` is low:
  - set `timeout_err`;
  - drop the strobes;
  - go to IDLE with no hit.
  - No automatic retry; a still-pending request is simply re-granted.
- **RESP**:
  - `ihit` or `dhit` = 1 for exactly this cycle, matching the latched source.
  - Strobes are low.
  - Next state is IDLE unconditionally. There is no grant in RESP, because the datapath still presents the request that was just satisfied.
- `ihit` and `dhit` are never high together, and never high outside RESP.

## Timing
- Reset at a clock edge with `RST`=1:
  - state = IDLE;
  - `ihit`, `dhit`, `ramREN`, `ramWEN`, `timeout_err` = 0;
  - `ramaddr`, `ramstore`, `imemload`, `dmemload` = 0.
- Reset asserted mid-ACCESS: strobes are low from the edge onward. A `ram_ready` at that same edge is ignored, because reset wins.
- Latency, with the request first seen in IDLE at cycle 0:
  - strobes high in cycles 1..k, where k is the cycle in which `ram_ready` is high;
  - hit in cycle k+1;
  - IDLE in cycle k+2.
  - Minimum is therefore 3 cycles per access.
- `ram_ready` outside ACCESS is ignored.
- `halt` rising during an I ACCESS does not abort it; the fetch completes normally.
- A request that drops in IDLE before the grant is not served.

## Test plan
- **Fetch**:
  - Stimulus: `iREN`=1, `iaddr`=0x100; `ram_ready` in the 3rd ACCESS cycle with `ramload`=0x8C220004.
  - Response: `ramREN`=1 and `ramaddr`=0x100 in cycles 1–3; `ihit`=1 only in cycle 4; `imemload`=0x8C220004 from then on.
- **Priority**:
  - Stimulus: `iREN`=1 at 0x100 and `dREN`=1 at 0x200 in the same cycle; `ram_ready` in the first ACCESS cycle each time.
  - Response: first access has `ramaddr`=0x200 and `dhit` in cycle 2; fetch of 0x100 follows with `ihit` in cycle 5.
- **Write**:
  - Stimulus: `dWEN`=1, `dREN`=1, `daddr`=0x300, `dstore`=0xDEADBEEF; `ram_ready` in the first ACCESS cycle.
  - Response: `ramWEN`=1 and `ramREN`=0 in cycle 1; `dhit` in cycle 2; `dmemload` unchanged.
- **Flush discard**:
  - Stimulus: fetch 0x100 granted; `iaddr` changes to 0x240 in ACCESS before `ram_ready`.
  - Response: no `ihit` and `imemload` unchanged; a new access to 0x240 is granted, and its `ihit` returns its `ramload`.
- **Timeout**:
  - Stimulus: `TIMEOUT`=4, D read with `ram_ready` held low.
  - Response: `ramREN` high for exactly 4 cycles; `timeout_err`=1 from then on, cleared only by `RST`; no `dhit`; request re-granted.
- **Halt and reset**:
  - Stimulus: `halt`=1 with `iREN`=1.
  - Response: no strobes ever.
  - Stimulus: `RST` pulsed in ACCESS with `ram_ready` in the same cycle.
  - Response: all outputs 0 next cycle; no hit.
